cu_fsm: RTL and testbench

- Multi-cycle control-unit sequencer for the RISC-V MCU; sits beside the CU decoder and the datapath.
- Sequences each instruction through fetch, execute and optional load-writeback cycles.
- Issues the datapath write and memory enables.
- Enters an interrupt cycle, which drives INTR_TAKEN into the decoder so that it selects PC_SRC=4.

---
 rtl/cu_fsm_pkg.sv | 25 ++
 rtl/cu_fsm.sv | 114 +++++++++++
 tb/tb_cu_fsm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cu_fsm_pkg.sv
// Shared constants for the multi-cycle control unit: state codes, RV32I opcodes and
// the SYSTEM funct3 values the sequencer distinguishes.
package cu_fsm_pkg;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_INTR  = 3'd4;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;

endpackage

// File: rtl/cu_fsm.sv
// Multi-cycle sequencer: fetch, execute, optional load writeback and interrupt entry.
// Moore outputs per state, with opcode/funct3 decode applied only in EXEC.
module cu_fsm
    import cu_fsm_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNC3,
    input  logic       INTR,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       INTR_TAKEN,
    output logic [1:0] STATE
);

    localparam int unsigned CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    logic [2:0]    state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Counter only advances inside WB; every other path returns it to zero.
    always_comb begin
        state_next = ST_INIT;
        cnt_next   = '0;
        case (state)
            ST_INIT:  state_next = ST_FETCH;
            ST_FETCH: state_next = ST_EXEC;
            ST_EXEC: begin
                if (OPCODE == OP_LOAD) state_next = ST_WB;
                else if (INTR)         state_next = ST_INTR;
                else                   state_next = ST_FETCH;
            end
            ST_WB: begin
                if (cnt < CNT_LAST) begin
                    state_next = ST_WB;
                    cnt_next   = cnt + 1'b1;
                end else begin
                    state_next = INTR ? ST_INTR : ST_FETCH;
                end
            end
            ST_INTR:  state_next = ST_FETCH;
            default:  state_next = ST_INIT;
        endcase
    end

    always_comb begin
        PC_WRITE   = 1'b0;
        REG_WRITE  = 1'b0;
        MEM_RDEN1  = 1'b0;
        MEM_RDEN2  = 1'b0;
        MEM_WE2    = 1'b0;
        CSR_WE     = 1'b0;
        INTR_TAKEN = 1'b0;
        if (!RST) begin
            case (state)
                ST_FETCH: MEM_RDEN1 = 1'b1;
                ST_EXEC: begin
                    case (OPCODE)
                        OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                            PC_WRITE  = 1'b1;
                            REG_WRITE = 1'b1;
                        end
                        OP_BRANCH: PC_WRITE = 1'b1;
                        OP_STORE: begin
                            MEM_WE2  = 1'b1;
                            PC_WRITE = 1'b1;
                        end
                        OP_LOAD:   MEM_RDEN2 = 1'b1;
                        OP_SYS: begin
                            PC_WRITE = 1'b1;
                            if (FUNC3 != F3_MRET) REG_WRITE = 1'b1;
                            if (FUNC3 == F3_CSRRW) CSR_WE = 1'b1;
                        end
                        default:   PC_WRITE = 1'b1;
                    endcase
                end
                ST_WB: begin
                    if (cnt < CNT_LAST) begin
                        MEM_RDEN2 = 1'b1;
                    end else begin
                        REG_WRITE = 1'b1;
                        PC_WRITE  = 1'b1;
                    end
                end
                ST_INTR: begin
                    INTR_TAKEN = 1'b1;
                    PC_WRITE   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign STATE = RST ? 2'b00 : state[1:0];

endmodule

// File: tb/tb_cu_fsm.sv
// Self-checking bench for cu_fsm: directed scenarios plus random instruction streams,
// compared cycle by cycle against an instruction-level timeline model.
module tb_cu_fsm;

    localparam int unsigned LAT = 3;

    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYS    = 7'b1110011;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       intr;
    logic       pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, csr_we, intr_taken;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    cu_fsm #(.MEM_LAT(LAT)) dut (
        .CLK        (clk),
        .RST        (rst),
        .OPCODE     (op),
        .FUNC3      (f3),
        .INTR       (intr),
        .PC_WRITE   (pc_write),
        .REG_WRITE  (reg_write),
        .MEM_RDEN1  (mem_rden1),
        .MEM_RDEN2  (mem_rden2),
        .MEM_WE2    (mem_we2),
        .CSR_WE     (csr_we),
        .INTR_TAKEN (intr_taken),
        .STATE      (state)
    );

    always #5 clk = ~clk;

    // Vector layout: {pc, reg, rden1, rden2, we2, csr, intr_taken, state[1:0]}
    localparam logic [8:0] V_ZERO  = 9'b0000000_00;
    localparam logic [8:0] V_FETCH = 9'b0010000_01;
    localparam logic [8:0] V_WAIT  = 9'b0001000_11;
    localparam logic [8:0] V_WBEND = 9'b1100000_11;
    localparam logic [8:0] V_INTR  = 9'b1000001_00;

    function automatic logic [8:0] exec_vec(input logic [6:0] o, input logic [2:0] f);
        logic [6:0] v;
        if (o inside {RTYPE, ITYPE, LUI, AUIPC, JAL, JALR}) v = 7'b1100000;
        else if (o == BRANCH)                              v = 7'b1000000;
        else if (o == STORE)                               v = 7'b1000100;
        else if (o == LOAD)                                v = 7'b0001000;
        else if (o == SYS && f == 3'b000)                  v = 7'b1000000;
        else if (o == SYS && f == 3'b001)                  v = 7'b1100010;
        else if (o == SYS)                                 v = 7'b1100000;
        else                                               v = 7'b1000000;
        return {v, 2'd2};
    endfunction

    function automatic logic pick_intr(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic step(input string tag, input logic r, input logic [6:0] o,
                        input logic [2:0] f, input logic i, input logic [8:0] exp);
        logic [8:0] obs;
        rst  = r;
        op   = o;
        f3   = f;
        intr = i;
        @(negedge clk);
        obs = {pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, csr_we, intr_taken, state};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    // One instruction's full timeline; interrupt entry follows iff INTR is high in the
    // instruction's last cycle.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f,
                             input int mode);
        int         n;
        logic       iv;
        logic       last_iv;
        logic [8:0] exp;
        n       = (o == LOAD) ? 2 + LAT : 2;
        last_iv = 1'b0;
        for (int c = 0; c < n; c++) begin
            iv = pick_intr(mode);
            if (c == 0)          exp = V_FETCH;
            else if (c == 1)     exp = exec_vec(o, f);
            else if (c < n - 1)  exp = V_WAIT;
            else                 exp = V_WBEND;
            step($sformatf("%s_c%0d", tag, c), 1'b0, o, f, iv, exp);
            last_iv = iv;
        end
        if (last_iv) step($sformatf("%s_intr", tag), 1'b0, o, f, pick_intr(mode), V_INTR);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ops [10];
        logic [6:0] ro;
        ops = '{RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYS};

        rst  = 1'b1;
        op   = RTYPE;
        f3   = 3'b000;
        intr = 1'b0;
        @(posedge clk);
        #1;
        step("reset0", 1'b1, RTYPE, 3'b000, 1'b1, V_ZERO);
        step("reset1", 1'b1, RTYPE, 3'b000, 1'b0, V_ZERO);
        step("init",   1'b0, RTYPE, 3'b000, 1'b0, V_ZERO);

        run_instr("add0",   RTYPE,  3'b000, 0);
        run_instr("add1",   RTYPE,  3'b000, 0);
        run_instr("load",   LOAD,   3'b010, 0);
        run_instr("store",  STORE,  3'b010, 0);
        run_instr("branch", BRANCH, 3'b000, 0);
        run_instr("csrrw",  SYS,    3'b001, 0);
        run_instr("mret",   SYS,    3'b000, 0);
        run_instr("csrrs",  SYS,    3'b010, 0);
        run_instr("nop",    7'b1111111, 3'b000, 0);
        run_instr("add_irq",  RTYPE, 3'b000, 1);
        run_instr("load_irq", LOAD,  3'b000, 1);
        run_instr("after_irq", ITYPE, 3'b000, 0);

        step("mr_fetch", 1'b0, LOAD, 3'b000, 1'b0, V_FETCH);
        step("mr_exec",  1'b0, LOAD, 3'b000, 1'b0, exec_vec(LOAD, 3'b000));
        step("mr_wb1",   1'b0, LOAD, 3'b000, 1'b0, V_WAIT);
        step("mr_rst",   1'b1, LOAD, 3'b000, 1'b1, V_ZERO);
        step("mr_init",  1'b0, LOAD, 3'b000, 1'b0, V_ZERO);
        run_instr("mr_reload", LOAD, 3'b000, 0);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 7) == 0) ro = 7'($urandom);
            else                           ro = ops[$urandom_range(0, 9)];
            run_instr($sformatf("rnd%0d", k), ro, 3'($urandom), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
